// File: rtl/blink_pkg.sv
// Shared constants for the blinker and blink_monitor: default widths, the default
// timeout and the monitor's FSM state encodings.
package blink_pkg;

    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned TIMEOUT_DEF     = 100_000_000;
    localparam int          SYNC_STAGES_DEF = 2;

    localparam logic [2:0] ST_ACQUIRE = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_HIGH    = 3'd2;
    localparam logic [2:0] ST_LOW     = 3'd3;
    localparam logic [2:0] ST_STUCK   = 3'd4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus rise/fall detection on
// the synchronized value; reusable for buttons and switches.
module sync_edge_det
    import blink_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              s_prev;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // so the chain shifts one stage per clock instead of collapsing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain  <= '0;
            s_prev <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], din};
            s_prev <= chain[STAGES-1];
        end
    end

    assign s    = chain[STAGES-1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

endmodule

// File: rtl/blink_monitor.sv
// Measures high time, low time and period of an asynchronous blinking signal in
// clk cycles; reports lock after a full period and flags a stuck line on timeout.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blink_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W:0]   period_cycles,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall;
    logic             edge_seen;
    logic             timed_out;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_meas;
    logic             high_known;

    sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (blink_in),
        .s   (s),
        .rise(rise),
        .fall(fall)
    );

    assign edge_seen = rise | fall;
    assign timed_out = (cnt == CNT_LIMIT);

    // high_meas holds the latest high time privately so the three published
    // results always change together on meas_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_ACQUIRE;
            cnt           <= '0;
            high_meas     <= '0;
            high_known    <= 1'b0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            locked        <= 1'b0;
            stuck         <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state != ST_STUCK && !edge_seen) begin
                if (timed_out) begin
                    state  <= ST_STUCK;
                    stuck  <= 1'b1;
                    locked <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                // Levels alternate, so the only edge HIGH and LOW can see is the one
                // that ends the current level.
                case (state)
                    ST_ACQUIRE: begin
                        cnt <= '0;
                        if (fall) state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            state      <= ST_HIGH;
                            cnt        <= CNT_ONE;
                            high_known <= 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_HIGH: begin
                        high_meas <= cnt;
                        cnt       <= CNT_ONE;
                        state     <= ST_LOW;
                    end
                    ST_LOW: begin
                        if (high_known) begin
                            high_cycles   <= high_meas;
                            low_cycles    <= cnt;
                            period_cycles <= {1'b0, high_meas} + {1'b0, cnt};
                            meas_valid    <= 1'b1;
                            locked        <= 1'b1;
                        end
                        high_known <= 1'b1;
                        cnt        <= CNT_ONE;
                        state      <= ST_HIGH;
                    end
                    ST_STUCK: begin
                        // Leaving on a fall means the high half of this period was never timed.
                        if (edge_seen) begin
                            state      <= s ? ST_HIGH : ST_LOW;
                            high_known <= s;
                            stuck      <= 1'b0;
                            cnt        <= CNT_ONE;
                        end
                    end
                    default: state <= ST_ACQUIRE;
                endcase
            end
        end
    end

endmodule
